// File: rtl/window3x3_ctrl.sv
// window3x3_ctrl: sequences column triples into the 3x3 sliding-window shift
// register, tracks the window centre position and holds each complete window
// until downstream has consumed it.
//
// Handshakes (both sides use the same valid/ready rule):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer raising valid keeps it high and its payload stable until the
//   transfer. ready may depend combinationally on the other side's state.
//   Column side: col_valid/col_ready; transfer is shift_en.
//   Window side: win_valid/win_ready; payload is win_x, win_y, line_end.
module window3x3_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             col_valid,
    output logic             col_ready,
    output logic             shift_en,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [COL_W-1:0] win_x,
    output logic [ROW_W-1:0] win_y,
    output logic             line_end,
    output logic             busy,
    output logic             frame_done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(2);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 2);
    localparam logic [ROW_W-1:0] ROW_INIT  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col_cnt;
    // row_cnt is the centre row of the window the next full column completes
    logic [ROW_W-1:0] row_cnt;
    logic             accept;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic, column-side ready and the end-of-frame pulse
    always_comb begin
        state_nxt  = state;
        col_ready  = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                // a held window blocks the shift register so it is not overwritten
                col_ready = !win_valid || win_ready;
                if (col_valid && col_ready && col_cnt == COL_LAST && row_cnt == ROW_LAST)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (win_valid && win_ready) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept    = col_valid && col_ready;
    assign shift_en  = accept;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // column / row position of the next column to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= ROW_INIT;
        end else if (state == S_IDLE && start) begin
            col_cnt <= '0;
            row_cnt <= ROW_INIT;
        end else if (accept) begin
            if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + ROW_ONE;
            end else begin
                col_cnt <= col_cnt + COL_ONE;
            end
        end else if (state == S_DONE) begin
            col_cnt <= '0;
            row_cnt <= ROW_INIT;
        end
    end

    // window descriptor: loaded from pre-increment counters on accept,
    // retired when consumed without a replacement column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_x     <= '0;
            win_y     <= '0;
            line_end  <= 1'b0;
        end else if (accept) begin
            // columns 0 and 1 only prime the register with the new line
            win_valid <= (col_cnt >= COL_FIRST);
            win_x     <= col_cnt - COL_ONE;
            win_y     <= row_cnt;
            line_end  <= (col_cnt == COL_LAST);
        end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window3x3_ctrl.sv
// tb_window3x3_ctrl: directed checks of window3x3_ctrl on a 5x5 frame.
module tb_window3x3_ctrl;

    localparam int W = 5;
    localparam int H = 5;
    localparam int COL_W = $clog2(W);
    localparam int ROW_W = $clog2(H);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             col_valid;
    logic             col_ready;
    logic             shift_en;
    logic             win_valid;
    logic             win_ready;
    logic [COL_W-1:0] win_x;
    logic [ROW_W-1:0] win_y;
    logic             line_end;
    logic             busy;
    logic             frame_done;
    logic [1:0]       dbg_state;

    int checks;
    int failures;

    logic [6:0] exp_q[$];

    window3x3_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .col_valid(col_valid), .col_ready(col_ready), .shift_en(shift_en),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_x(win_x), .win_y(win_y), .line_end(line_end),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; col_valid = 1'b0; win_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; col_valid = 1'b1; win_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({win_valid, line_end, frame_done, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {win_valid, line_end, frame_done, busy});
        end
        checks++;
        if ({col_ready, shift_en} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00", {col_ready, shift_en});
        end
        checks++;
        if (win_x !== 3'd0 || win_y !== 3'd0) begin
            failures++;
            $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", win_x, win_y);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        col_valid = 1'b0; win_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_reject();
        col_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({col_ready, shift_en, busy} !== 3'b000) begin
                failures++;
                $display("FAIL idle_reject cyc=%0d got=%b exp=000", i, {col_ready, shift_en, busy});
            end
        end
        col_valid = 1'b0;
        @(negedge clk);
    endtask

    // full frame with win_ready high; bubbles toggles col_valid every cycle
    task automatic run_frame(input bit bubbles);
        int accepts, mcol, mrow, pcol, prow, acc_last_cyc, fd_cnt, cyc;
        bit prev_acc, exp_wv, exp_se, done;
        logic [6:0] exp_w;
        exp_q.delete();
        for (int y = 1; y <= H - 2; y++)
            for (int x = 1; x <= W - 2; x++)
                exp_q.push_back({3'(x), 3'(y), (x == W - 2)});
        win_ready = 1'b1; col_valid = 1'b0;
        pulse_start();
        accepts = 0; mcol = 0; mrow = 1; pcol = 0; prow = 0; prev_acc = 1'b0;
        acc_last_cyc = -10; fd_cnt = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            exp_wv = prev_acc && (pcol >= 2);
            checks++;
            if (win_valid !== exp_wv) begin
                failures++;
                $display("FAIL frame_win_valid b=%0d cyc=%0d got=%b exp=%b", bubbles, cyc, win_valid, exp_wv);
            end
            if (win_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL frame_extra_window got=(%0d,%0d) exp=none", win_x, win_y);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({win_x, win_y, line_end} !== exp_w) begin
                        failures++;
                        $display("FAIL frame_window b=%0d got=(%0d,%0d,le=%b) exp=(%0d,%0d,le=%b)",
                                 bubbles, win_x, win_y, line_end, exp_w[6:4], exp_w[3:1], exp_w[0]);
                    end
                end
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                checks++;
                if (cyc != acc_last_cyc + 2) begin
                    failures++;
                    $display("FAIL frame_done_time got=%0d exp=%0d", cyc, acc_last_cyc + 2);
                end
                done = 1'b1;
            end
            col_valid = bubbles ? ((cyc % 2) == 0) : 1'b1;
            #1;
            exp_se = col_valid && (accepts < W * H - 2 * W);
            checks++;
            if (shift_en !== exp_se) begin
                failures++;
                $display("FAIL frame_shift_en b=%0d cyc=%0d got=%b exp=%b", bubbles, cyc, shift_en, exp_se);
            end
            prev_acc = exp_se; pcol = mcol; prow = mrow;
            if (exp_se) begin
                accepts++;
                if (accepts == W * H - 2 * W) acc_last_cyc = cyc;
                if (mcol == W - 1) begin mcol = 0; mrow++; end
                else mcol++;
            end
            @(negedge clk);
            cyc++;
        end
        col_valid = 1'b0;
        checks++;
        if (fd_cnt != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL frame_totals b=%0d got=fd%0d/left%0d exp=fd1/left0", bubbles, fd_cnt, exp_q.size());
        end
        #1;
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_back_idle got=%b%b exp=00", busy, frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit found;
        apply_reset();
        pulse_start();
        col_valid = 1'b1; win_ready = 1'b1; found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (win_valid === 1'b1 && win_x == 3'd2 && win_y == 3'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_reach got=not_found exp=(2,1)");
        end
        win_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({col_ready, shift_en, win_valid} !== 3'b001 || win_x !== 3'd2 || win_y !== 3'd1) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=rdy%b se%b wv%b (%0d,%0d) exp=rdy0 se0 wv1 (2,1)",
                         i, col_ready, shift_en, win_valid, win_x, win_y);
            end
            @(negedge clk);
        end
        win_ready = 1'b1;
        #1;
        checks++;
        if ({col_ready, shift_en} !== 2'b11 || win_x !== 3'd2) begin
            failures++;
            $display("FAIL bp_release got=rdy%b se%b x%0d exp=rdy1 se1 x2", col_ready, shift_en, win_x);
        end
        @(negedge clk);
        checks++;
        if (win_valid !== 1'b1 || win_x !== 3'd3 || win_y !== 3'd1 || line_end !== 1'b1) begin
            failures++;
            $display("FAIL bp_next got=wv%b (%0d,%0d) le%b exp=wv1 (3,1) le1", win_valid, win_x, win_y, line_end);
        end
        apply_reset();
    endtask

    task automatic test_reset_start();
        bit found;
        int acc;
        pulse_start();
        col_valid = 1'b1; win_ready = 1'b1; found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (win_valid === 1'b1 && win_x == 3'd1 && win_y == 3'd1) found = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (!found || win_valid !== 1'b1 || win_x !== 3'd2 || win_y !== 3'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rs_start_ignored got=f%b wv%b (%0d,%0d) busy%b exp=f1 wv1 (2,1) busy1",
                     found, win_valid, win_x, win_y, busy);
        end
        @(negedge clk);
        checks++;
        if (win_x !== 3'd3 || win_y !== 3'd1) begin
            failures++;
            $display("FAIL rs_continue got=(%0d,%0d) exp=(3,1)", win_x, win_y);
        end
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (win_valid === 1'b1 && win_x == 3'd2 && win_y == 3'd2) found = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {win_valid, line_end, frame_done, busy, col_ready, shift_en} !== 6'b0
            || win_x !== 3'd0 || win_y !== 3'd0) begin
            failures++;
            $display("FAIL rs_midframe got=f%b flags=%b (%0d,%0d) exp=f1 flags=000000 (0,0)", found,
                     {win_valid, line_end, frame_done, busy, col_ready, shift_en}, win_x, win_y);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rs_no_done cyc=%0d got=fd%b busy%b exp=fd0 busy0", i, frame_done, busy);
            end
        end
        pulse_start();
        acc = 0; found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (win_valid === 1'b1) found = 1'b1;
            else begin
                #1;
                if (shift_en === 1'b1) acc++;
                @(negedge clk);
            end
        end
        checks++;
        if (!found || acc != 3 || win_x !== 3'd1 || win_y !== 3'd1) begin
            failures++;
            $display("FAIL rs_restart got=f%b acc%0d (%0d,%0d) exp=f1 acc3 (1,1)", found, acc, win_x, win_y);
        end
        apply_reset();
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_idle_reject();
        run_frame(1'b0);
        run_frame(1'b1);
        test_backpressure();
        test_reset_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
